// File: rtl/motor_pkg.sv
// Shared definitions for the rover drive-motor control blocks:
// controller state encoding, direction codes and timer width.
package motor_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        COAST   = 3'd2,
        FAULT   = 3'd3,
        LOCKOUT = 3'd4
    } motor_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    localparam int TIMER_W = 20;

endpackage

// File: rtl/ocp_filter.sv
// Overcurrent flag conditioning: 2-FF synchronizer followed by a run-length
// counter, so only OCP_FILT consecutive synchronized lows raise trip.
module ocp_filter #(
    parameter int OCP_FILT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic ocp_n,
    output logic trip
);

    localparam int CNT_W = (OCP_FILT > 1) ? $clog2(OCP_FILT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OCP_FILT - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Synchronizer resets to the inactive (high) level so reset never trips.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= ocp_n;
            sync2_reg <= sync1_reg;
            if (sync2_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // cnt_reg holds the lows seen before the current one, hence the -1 ceiling.
    assign trip = ~sync2_reg && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/hbridge_dir_ctrl.sv
// Steers one PWM stream onto the IN1/IN2 pins of an H-bridge, with coast
// dead-time on reversal/stop and overcurrent fault retry/lockout handling.
module hbridge_dir_ctrl
    import motor_pkg::*;
#(
    parameter logic [TIMER_W-1:0] DEADTIME_CYC = 20'd500000,
    parameter logic [TIMER_W-1:0] FAULT_HOLD   = 20'd1000000,
    parameter int                 OCP_FILT     = 4,
    parameter int                 MAX_RETRY    = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    input  logic enable,
    input  logic dir_cmd,
    input  logic ocp_n,
    output logic in1,
    output logic in2,
    output logic busy,
    output logic fault,
    output logic lockout
);

    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    logic trip;

    ocp_filter #(
        .OCP_FILT (OCP_FILT)
    ) u_ocp_filter (
        .clk   (clk),
        .reset (reset),
        .ocp_n (ocp_n),
        .trip  (trip)
    );

    motor_state_t       state_reg, state_next;
    motor_state_t       coast_to_reg, coast_to_next;
    logic               cur_dir_reg, cur_dir_next;
    logic [2:0]         retry_reg, retry_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic               dead_done;
    logic               hold_done;

    assign dead_done = (timer_reg == DEADTIME_CYC - TIMER_W'(1));
    assign hold_done = (timer_reg == FAULT_HOLD - TIMER_W'(1));

    always_comb begin
        state_next    = state_reg;
        coast_to_next = coast_to_reg;
        cur_dir_next  = cur_dir_reg;
        retry_next    = retry_reg;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next   = DRIVE;
                    cur_dir_next = dir_cmd;
                end
            end
            // Ordering below encodes trip > stop > reversal.
            DRIVE: begin
                if (trip) begin
                    state_next = FAULT;
                end else if (!enable) begin
                    state_next    = COAST;
                    coast_to_next = IDLE;
                end else if (dir_cmd != cur_dir_reg) begin
                    state_next    = COAST;
                    coast_to_next = DRIVE;
                end
            end
            COAST: begin
                if (trip) begin
                    state_next = FAULT;
                end else if (dead_done) begin
                    if (coast_to_reg == DRIVE && enable) begin
                        state_next   = DRIVE;
                        cur_dir_next = dir_cmd;
                    end else begin
                        state_next = IDLE;
                        retry_next = '0;
                    end
                end
            end
            FAULT: begin
                if (hold_done) begin
                    if (retry_reg == RETRY_LIMIT) begin
                        state_next = LOCKOUT;
                    end else begin
                        state_next    = COAST;
                        coast_to_next = IDLE;
                    end
                end
            end
            LOCKOUT: begin
                if (!enable) begin
                    state_next = IDLE;
                    retry_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (state_next == FAULT && state_reg != FAULT) begin
            retry_next = retry_reg + 3'd1;
        end

        // Timer restarts on every state change and saturates instead of wrapping.
        if (state_next != state_reg) begin
            timer_next = '0;
        end else if (&timer_reg) begin
            timer_next = timer_reg;
        end else begin
            timer_next = timer_reg + TIMER_W'(1);
        end
    end

    // Outputs are decoded from the next state so they line up with state_reg.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            coast_to_reg <= IDLE;
            cur_dir_reg  <= DIR_FWD;
            retry_reg    <= '0;
            timer_reg    <= '0;
            in1          <= 1'b0;
            in2          <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            lockout      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            coast_to_reg <= coast_to_next;
            cur_dir_reg  <= cur_dir_next;
            retry_reg    <= retry_next;
            timer_reg    <= timer_next;
            in1          <= pwm_in && (state_next == DRIVE) && (cur_dir_next == DIR_FWD);
            in2          <= pwm_in && (state_next == DRIVE) && (cur_dir_next == DIR_REV);
            busy         <= (state_next == COAST);
            fault        <= (state_next == FAULT) || (state_next == LOCKOUT);
            lockout      <= (state_next == LOCKOUT);
        end
    end

endmodule
